// File: rtl/vga_timing_engine.sv
// rtl/vga_timing_engine.sv - VGA raster timing with latency-matched sync/colour output (optional VGA_TEST_PATTERN_EN)
module vga_timing_engine #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int COORD_BITS      = 10,
    parameter int COLOR_BITS      = 10,
    parameter int PIPE_LAT        = 2,
    parameter int SCALE_LOG2      = 0,
    parameter bit SYNC_ACTIVE_LOW = 1
) (
    input  logic                    clock_25,
    input  logic                    reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                    test_mode,
`endif
    input  logic [3*COLOR_BITS-1:0] pixel_in,
    output logic [COORD_BITS-1:0]   X,
    output logic [COORD_BITS-1:0]   Y,
    output logic [COORD_BITS-1:0]   cell_x,
    output logic [COORD_BITS-1:0]   cell_y,
    output logic                    display_area,
    output logic                    frame_start,
    output logic [COLOR_BITS-1:0]   VGA_R,
    output logic [COLOR_BITS-1:0]   VGA_G,
    output logic [COLOR_BITS-1:0]   VGA_B,
    output logic                    VGA_HS,
    output logic                    VGA_VS,
    output logic                    VGA_BLANK,
    output logic                    VGA_SYNC,
    output logic                    VGA_CLK
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CW      = COORD_BITS + 1;
    localparam logic [COORD_BITS-1:0] H_LAST = COORD_BITS'(H_TOTAL - 1);
    localparam logic [COORD_BITS-1:0] V_LAST = COORD_BITS'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic ACT_LVL = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
`ifdef VGA_TEST_PATTERN_EN
    localparam int PW    = 3 + COORD_BITS;
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
`else
    localparam int PW = 3;
`endif

    generate
        if (H_TOTAL > (1 << COORD_BITS)) begin : g_bad_h
            $error("H_TOTAL does not fit in COORD_BITS");
        end
        if (V_TOTAL > (1 << COORD_BITS)) begin : g_bad_v
            $error("V_TOTAL does not fit in COORD_BITS");
        end
        if (PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_bad_lat
            $error("PIPE_LAT out of range 0..7");
        end
        if (SCALE_LOG2 < 0 || SCALE_LOG2 > 4) begin : g_bad_scale
            $error("SCALE_LOG2 out of range 0..4");
        end
    endgenerate

    logic [COORD_BITS-1:0]   h_q, h_d, v_q, v_d;
    logic [CW-1:0]           h_ext, v_ext;
    logic                    hs_raw, vs_raw;
    logic [PW-1:0]           tap_in, tap_out;
    logic                    tap_da, tap_hs, tap_vs;
    logic [3*COLOR_BITS-1:0] rgb_q, rgb_d;
    logic                    blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    always_ff @(posedge clock_25) begin
        if (!reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Extra bit keeps boundaries equal to 2^COORD_BITS from aliasing to 0
    assign h_ext        = {1'b0, h_q};
    assign v_ext        = {1'b0, v_q};
    assign X            = h_q;
    assign Y            = v_q;
    assign cell_x       = h_q >> SCALE_LOG2;
    assign cell_y       = v_q >> SCALE_LOG2;
    assign display_area = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    assign frame_start  = (h_q == '0) && (v_q == '0);
    assign hs_raw       = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
    assign vs_raw       = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);

`ifdef VGA_TEST_PATTERN_EN
    assign tap_in = {h_q, vs_raw, hs_raw, display_area};
`else
    assign tap_in = {vs_raw, hs_raw, display_area};
`endif

    // Flags travel active-high; all-zero is the inactive stage value
    generate
        if (PIPE_LAT == 0) begin : g_nopipe
            assign tap_out = tap_in;
        end else begin : g_pipe
            logic [PW-1:0] pipe_q [PIPE_LAT];
            logic [PW-1:0] pipe_d [PIPE_LAT];
            always_comb begin
                pipe_d[0] = tap_in;
                for (int i = 1; i < PIPE_LAT; i++) pipe_d[i] = pipe_q[i-1];
            end
            always_ff @(posedge clock_25) begin
                for (int i = 0; i < PIPE_LAT; i++) begin
                    if (!reset) pipe_q[i] <= '0;
                    else        pipe_q[i] <= pipe_d[i];
                end
            end
            assign tap_out = pipe_q[PIPE_LAT-1];
        end
    endgenerate

    assign tap_da = tap_out[0];
    assign tap_hs = tap_out[1];
    assign tap_vs = tap_out[2];

`ifdef VGA_TEST_PATTERN_EN
    logic [COORD_BITS-1:0] tap_h, bar_idx;
    logic [2:0]            bar_mask;
    logic [3*COLOR_BITS-1:0] bar_rgb;
    assign tap_h   = tap_out[PW-1:3];
    assign bar_idx = tap_h / COORD_BITS'(BAR_W);
    always_comb begin
        case (bar_idx)
            0:       bar_mask = 3'b111;
            1:       bar_mask = 3'b110;
            2:       bar_mask = 3'b011;
            3:       bar_mask = 3'b010;
            4:       bar_mask = 3'b101;
            5:       bar_mask = 3'b100;
            6:       bar_mask = 3'b001;
            default: bar_mask = 3'b000;
        endcase
    end
    assign bar_rgb = {{COLOR_BITS{bar_mask[2]}}, {COLOR_BITS{bar_mask[1]}}, {COLOR_BITS{bar_mask[0]}}};
`endif

    always_comb begin
        rgb_d   = '0;
        blank_d = tap_da;
        hs_d    = tap_hs ? ACT_LVL : ~ACT_LVL;
        vs_d    = tap_vs ? ACT_LVL : ~ACT_LVL;
        if (tap_da) begin
            rgb_d = pixel_in;
`ifdef VGA_TEST_PATTERN_EN
            if (test_mode) rgb_d = bar_rgb;
`endif
        end
    end

    always_ff @(posedge clock_25) begin
        if (!reset) begin
            rgb_q   <= '0;
            blank_q <= 1'b0;
            hs_q    <= ~ACT_LVL;
            vs_q    <= ~ACT_LVL;
        end else begin
            rgb_q   <= rgb_d;
            blank_q <= blank_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

    assign VGA_R     = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];
    assign VGA_G     = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
    assign VGA_B     = rgb_q[COLOR_BITS-1:0];
    assign VGA_HS    = hs_q;
    assign VGA_VS    = vs_q;
    assign VGA_BLANK = blank_q;
    assign VGA_SYNC  = 1'b0;
    assign VGA_CLK   = clock_25;

endmodule

// File: doc/vga_timing_engine.md
VGA_TIMING_ENGINE -- requirements
Module: vga_timing_engine

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL provide parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal front porch/sync/back porch in pixels.
REQ-003 SHALL provide parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL provide parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical front porch/sync/back porch in lines.
REQ-005 SHALL provide parameter COORD_BITS, default 10, width of counters and coordinates.
REQ-006 SHALL provide parameter COLOR_BITS, default 10, width per colour channel.
REQ-007 SHALL provide parameter PIPE_LAT, default 2 (range 0..7), pixel-source latency in cycles.
REQ-008 SHALL provide parameter SCALE_LOG2, default 0 (range 0..4), pixel-to-cell shift.
REQ-009 SHALL provide parameter SYNC_ACTIVE_LOW, default 1, sync polarity.
REQ-010 clock_25  in  1  pixel clock, all logic on rising edge.
REQ-011 reset  in  1  synchronous, active-low reset.
REQ-012 pixel_in  in  3*COLOR_BITS  {R,G,B} for the coordinate issued PIPE_LAT cycles earlier.
REQ-013 X, Y  out  COORD_BITS  current pixel coordinate (request side).
REQ-014 cell_x, cell_y  out  COORD_BITS  X>>SCALE_LOG2, Y>>SCALE_LOG2.
REQ-015 display_area  out  1  request-side coordinate is visible.
REQ-016 frame_start  out  1  one-cycle pulse at h=0, v=0.
REQ-017 VGA_R, VGA_G, VGA_B  out  COLOR_BITS each  registered colour.
REQ-018 VGA_HS, VGA_VS  out  1  registered syncs; VGA_BLANK  out  1  registered, low during blanking; VGA_SYNC  out  1  constant 0; VGA_CLK  out  1  equals clock_25.

Function
REQ-019 h_count SHALL count 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP), wrapping to 0; v_count SHALL increment only on h wrap, counting 0..V_TOTAL-1, then wrapping to 0.
REQ-020 X/Y SHALL be h_count/v_count registers directly (no extra latency).
REQ-021 display_area SHALL be 1 iff h_count<H_ACTIVE and v_count<V_ACTIVE.
REQ-022 Raw hsync SHALL be active iff H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC; raw vsync active iff V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC; active level is 0 when SYNC_ACTIVE_LOW=1, else 1.
REQ-023 display_area, raw hsync, raw vsync SHALL pass through a PIPE_LAT-stage shift register, then one output register, so VGA_* lag X/Y by exactly PIPE_LAT+1 cycles.
REQ-024 Output register: VGA_R/G/B = pixel_in when delayed display_area=1, else 0; VGA_BLANK = delayed display_area.
REQ-025 frame_start SHALL be combinational on the request side (h_count=0 and v_count=0), asserted exactly once per frame.
REQ-026 Counter widths SHALL be checked: H_TOTAL and V_TOTAL each ≤ 2^COORD_BITS, else elaboration error.
REQ-027 Vertical wrap SHALL occur on the same edge as horizontal wrap from h=H_TOTAL-1, v=V_TOTAL-1 to (0,0).

Reset
REQ-028 While reset=0 at a clock edge: h_count=v_count=0, all delay-line stages cleared to inactive (syncs at inactive level, display_area 0), VGA_R/G/B=0, VGA_BLANK=0.
REQ-029 Reset mid-frame SHALL abort the frame; first cycle after release SHALL present X=0,Y=0, frame_start=1.
REQ-030 Outputs SHALL show no active sync or colour for the PIPE_LAT+1 cycles after release until the pipeline fills.

Configuration
REQ-031 Macro VGA_TEST_PATTERN_EN: when defined, add input test_mode (1 bit); when test_mode=1, pixel_in is ignored and the output stage shows 8 vertical colour bars of width H_ACTIVE/8 (white, yellow, cyan, green, magenta, red, blue, black; full-scale channels) aligned to the delayed coordinate; when undefined, no test_mode port and no pattern logic.

Verification
REQ-032 Defaults, reset released at t0 -> frame_start at t0 and every 420000 cycles; X wraps 799->0, Y wraps 524->0.
REQ-033 Defaults -> VGA_HS low for h_count 656..751 (96 cycles) delayed 3 cycles; VGA_VS low on lines 490..491 only.
REQ-034 PIPE_LAT=2, pixel_in driven as {X[9:0],Y[9:0],10'h3FF} with 2-cycle delay -> VGA_R equals X three cycles earlier in the active area; RGB=0, VGA_BLANK=0 at X≥640.
REQ-035 reset=0 for 1 cycle at X=300,Y=200 -> next cycle X=0,Y=0, frame_start=1, VGA_HS/VS inactive for 3 cycles.
REQ-036 SCALE_LOG2=3, X=645,Y=479 -> cell_x=80, cell_y=59.
REQ-037 VGA_TEST_PATTERN_EN defined, test_mode=1 -> output pixel 0..79 = all channels 10'h3FF, 80..159 = R,G 10'h3FF, B 0, 560..639 = 0.
